// File: rtl/collision_pkg.sv
// Shared types and pair-numbering helpers for the collision scheduler.
package collision_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    COMMIT
  } sched_state_t;

  function automatic int npairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Row a contributes (n-1-a) pairs, so row start = a*(2n-a-1)/2
  function automatic int pair_index(input int a, input int b, input int n);
    return a * (2 * n - a - 1) / 2 + (b - a - 1);
  endfunction

endpackage

// File: rtl/collision_scheduler_pair_walker.sv
// Lexicographic (a,b) pair generator with a<b; parks at (0,1) whenever start is high.
module pair_walker #(
  parameter int N_OBJ = 4,
  parameter int IW    = $clog2(N_OBJ)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          advance,
  output logic [IW-1:0] a,
  output logic [IW-1:0] b,
  output logic          last
);

  assign last = (a == IW'(N_OBJ - 2)) && (b == IW'(N_OBJ - 1));

  // Wrapping back to (0,1) after the last pair keeps the outputs parked between sweeps
  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      b <= '0;
    end else if (start || (advance && last)) begin
      a <= '0;
      b <= IW'(1);
    end else if (advance) begin
      if (b == IW'(N_OBJ - 1)) begin
        a <= a + IW'(1);
        b <= a + IW'(2);
      end else begin
        b <= b + IW'(1);
      end
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Frame-synchronous sweep of all object pairs through one shared collision detector.
// Optional COLLISION_PAIR_MATRIX_EN adds the per-pair hit output pair_hits.
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int N_OBJ      = 4,
  parameter int CD_LATENCY = 1,
  parameter int IW         = $clog2(N_OBJ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [N_OBJ-1:0] obj_valid,
  output logic [IW-1:0]    cd_idx_a,
  output logic [IW-1:0]    cd_idx_b,
  output logic             cd_req,
  input  logic             cd_hit,
  output logic [N_OBJ-1:0] collide_flags,
  output logic             busy,
  output logic             done,
  output logic             overrun
`ifdef COLLISION_PAIR_MATRIX_EN
  ,
  output logic [npairs(N_OBJ)-1:0] pair_hits
`endif
);

  localparam int NPAIRS = npairs(N_OBJ);
  localparam int TAG_W  = 1 + 2 * IW;
  localparam int LAT_W  = (CD_LATENCY > 1) ? $clog2(CD_LATENCY) : 1;

  sched_state_t     state, state_nxt;
  logic [N_OBJ-1:0] vmask;
  logic [N_OBJ-1:0] shadow, shadow_nxt;
  logic [LAT_W-1:0] drain_cnt;
  logic             walk_last;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic             tag_req;
  logic [IW-1:0]    tag_a, tag_b;
  logic             result_hit;

  pair_walker #(.N_OBJ(N_OBJ), .IW(IW)) u_walker (
    .clk    (clk),
    .reset  (reset),
    .start  (state != ISSUE),
    .advance(state == ISSUE),
    .a      (cd_idx_a),
    .b      (cd_idx_b),
    .last   (walk_last)
  );

  assign cd_req = (state == ISSUE) && vmask[cd_idx_a] && vmask[cd_idx_b];
  assign busy   = (state != IDLE);
  assign done   = (state == COMMIT);
  assign tag_in = {cd_req, cd_idx_a, cd_idx_b};

  // Tag pipe mirrors the detector latency so each cd_hit meets its own pair
  generate
    if (CD_LATENCY == 0) begin : g_tag_comb
      assign tag_out = tag_in;
    end else begin : g_tag_pipe
      logic [TAG_W-1:0] pipe [CD_LATENCY];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < CD_LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= tag_in;
          for (int i = 1; i < CD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign tag_out = pipe[CD_LATENCY-1];
    end
  endgenerate

  assign {tag_req, tag_a, tag_b} = tag_out;
  assign result_hit = tag_req && cd_hit;

  always_comb begin
    shadow_nxt = shadow;
    if (result_hit) begin
      shadow_nxt[tag_a] = 1'b1;
      shadow_nxt[tag_b] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = ISSUE;
      ISSUE:   if (walk_last) state_nxt = (CD_LATENCY > 0) ? DRAIN : COMMIT;
      DRAIN:   if (int'(drain_cnt) == CD_LATENCY - 1) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags load on entry to COMMIT, folding in the result that lands that same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      vmask         <= '0;
      shadow        <= '0;
      collide_flags <= '0;
      drain_cnt     <= '0;
      overrun       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && frame_start) begin
        vmask  <= obj_valid;
        shadow <= '0;
      end else begin
        shadow <= shadow_nxt;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state_nxt == COMMIT) collide_flags <= shadow_nxt;
      if (frame_start && busy) overrun <= 1'b1;
    end
  end

`ifdef COLLISION_PAIR_MATRIX_EN
  localparam int PW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  logic [NPAIRS-1:0] pair_shadow, pair_shadow_nxt;
  logic [PW-1:0]     tag_pidx;

  assign tag_pidx = PW'(pair_index(int'(tag_a), int'(tag_b), N_OBJ));

  always_comb begin
    pair_shadow_nxt = pair_shadow;
    if (result_hit) pair_shadow_nxt[tag_pidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_shadow <= '0;
      pair_hits   <= '0;
    end else begin
      if (state == IDLE && frame_start) pair_shadow <= '0;
      else pair_shadow <= pair_shadow_nxt;
      if (state_nxt == COMMIT) pair_hits <= pair_shadow_nxt;
    end
  end
`endif

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Frame-synchronous scheduler that time-shares one collision detector across every unordered pair of on-screen oriented boxes. On each frame start it sweeps all pairs (i<j), issues each valid pair to the shared detector, collects the per-pair hit results, and publishes a per-object collision mask atomically at the end of the sweep. The display colour path and the game logic consume this mask. Neither needs to know how many pair tests the sweep ran.

## Interface
- N_OBJ, default 4: number of objects, ≥2; NPAIRS = N_OBJ*(N_OBJ-1)/2
- CD_LATENCY, default 1: cycles from pair issue to valid result at cd_hit, ≥0; 0 means the detector is combinational
- IW, default $clog2(N_OBJ): object index width
- Clk  in  1  system clock; one clock domain
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse at vertical blank start
- obj_valid  in  N_OBJ  per-object enable; sampled only on an accepted frame_start
- cd_idx_a, cd_idx_b  out  IW each  pair presented to the detector's OBB muxes; a < b
- cd_req  out  1  the pair on cd_idx_a/b is a real test
- cd_hit  in  1  detector result for the pair issued CD_LATENCY cycles earlier
- collide_flags  out  N_OBJ  bit k set if object k hit any valid partner in the last completed sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse; collide_flags updated this cycle
- overrun  out  1  sticky; frame_start arrived while busy; cleared by Reset only

## Operation
- FSM states:
  - IDLE: on frame_start, latch obj_valid into vmask, clear the shadow mask, go to ISSUE.
  - ISSUE: exactly one pair per cycle, in lexicographic order (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1). After the last pair, go to DRAIN if CD_LATENCY>0, otherwise go to COMMIT.
  - DRAIN: wait CD_LATENCY cycles.
  - COMMIT: copy the shadow mask into collide_flags, pulse done, return to IDLE.
- cd_req = vmask[a] & vmask[b]. Invalid pairs still consume their ISSUE slot with cd_req=0, so sweep length is fixed.
- A tag pipe, CD_LATENCY deep, carries {req,a,b} alongside the detector pipeline. When the pipe output has req=1 and cd_hit=1, set shadow[a] and shadow[b]. cd_hit is ignored when the tag req=0.
- busy = 1 in ISSUE, DRAIN and COMMIT.
- frame_start while busy: ignored for sequencing, sets overrun.
- frame_start in the COMMIT cycle: counts as busy. It is ignored and sets overrun.
- cd_idx_a/b hold (0,1) outside ISSUE, with cd_req=0.
- Reset: state IDLE; the following clear to 0: collide_flags, shadow, vmask, tag pipe, cd_idx_a, cd_idx_b, cd_req, busy, done, overrun.
- Reset mid-sweep abandons the sweep and discards in-flight results. A result returning after Reset is never recorded.

## Timing
- frame_start high at edge t: ISSUE occupies cycles t+1 … t+NPAIRS.
- DRAIN occupies cycles t+NPAIRS+1 … t+NPAIRS+CD_LATENCY.
- COMMIT is cycle t+NPAIRS+CD_LATENCY+1. done is high in that cycle, and the new collide_flags are visible from the same edge.
- Sweep length = NPAIRS+CD_LATENCY+1 cycles. Example: N_OBJ=4, CD_LATENCY=1 gives 8 cycles.
- The result for the pair issued in cycle c is sampled in cycle c+CD_LATENCY. The last result lands in the final DRAIN cycle, or in the final ISSUE cycle when CD_LATENCY=0.
- collide_flags are stable between done pulses and never show a partial sweep.

## Configuration
- COLLISION_PAIR_MATRIX_EN defined:
  - adds output pair_hits [NPAIRS-1:0], the per-pair hit bits, indexed in issue order.
  - pair_hits follows the same shadow/commit rules and reset value (0) as collide_flags.
- Undefined: pair_hits port and its shadow register are absent. All other behaviour is identical.

## Structure
- collision_pkg holds:
  - the sched_state_t enum (IDLE, ISSUE, DRAIN, COMMIT)
  - the function npairs(n)
  - the function pair_index(a,b,n), giving the issue-order index
- Sub-module pair_walker: generates (a,b) lexicographically, with start and advance inputs and a last output. The scheduler owns the FSM, vmask, tag pipe and masks.

## Test plan
- N_OBJ=4, CD_LATENCY=1, all valid, cd_hit=1 only for pair (1,3):
  - collide_flags=4'b1010
  - done 8 cycles after frame_start
  - cd_idx sequence (0,1),(0,2),(0,3),(1,2),(1,3),(2,3)
- obj_valid=4'b1011, cd_hit forced 1 every cycle:
  - cd_req low for pairs (0,2),(1,2),(2,3)
  - collide_flags=4'b1011
- Two sweeps, first with hit (0,1), second with no hits:
  - flags 4'b0011 after the first done
  - 4'b0000 after the second
  - no intermediate values in between
- frame_start re-pulsed during ISSUE and again during COMMIT:
  - sweep completes unchanged
  - overrun=1 and stays set
  - next IDLE frame_start starts a normal sweep
- Reset asserted mid-DRAIN with cd_hit=1:
  - all outputs 0 the next cycle
  - no flag set afterwards
  - next sweep correct
- CD_LATENCY=0, N_OBJ=2, hit on (0,1):
  - done 2 cycles after frame_start
  - flags 2'b11
  - with COLLISION_PAIR_MATRIX_EN defined, pair_hits=1'b1
